neuron_sched: RTL and testbench
===============================

NEURON_SCHED -- requirements
Module: neuron_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one neuron datapath.
REQ-002 Parameter SETTLE_CYC, default 4: cycles the operands are held before Q is sampled.
REQ-003 Parameter PWR_CYC, default 2: supply-enable to first-drive delay, in cycles.
REQ-004 Parameter IDLE_OFF, default 8: idle cycles before supplies are gated off.
REQ-005 Port CK, input, 1: single clock; one clock; reset is asynchronous and active-low.
REQ-006 Port RSTB, input, 1: asynchronous active-low reset.
REQ-007 Port req_valid, input, NREQ: per-requester operand-set valid.
REQ-008 Port req_data, input, NREQ*64: per-requester operands D7..D0, 8 bits each, D0 in bits [7:0].
REQ-009 Port req_ready, output, NREQ: one-hot accept strobe.
REQ-010 Port resp_valid, output, 1: result valid.
REQ-011 Port resp_ready, input, 1: result consumer ready.
REQ-012 Port resp_data, output, 8: ReLU result.
REQ-013 Port resp_id, output, clog2(NREQ): requester index of resp_data.
REQ-014 Port nrn_d, output, 64: operand bus to the neuron D0..D7 inputs.
REQ-015 Port nrn_q, input, 8: neuron Q output.
REQ-016 Port nrn_pwr_en, output, 8: supply enables for neuron stages VDD1..VDD8.
REQ-017 Port busy, output, 1: high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, PWRUP, DRIVE, SETTLE, CAPT, RESP.
REQ-019 IDLE with any req_valid SHALL grant round-robin, starting at rr_ptr, lowest index first from there.
- pulse req_ready[g] for one cycle.
- latch req_data[g] and g.
- set rr_ptr = (g+1) mod NREQ.
REQ-020 The grant transition from IDLE SHALL go to PWRUP if nrn_pwr_en==0, else to DRIVE.
REQ-021 PWRUP SHALL drive nrn_pwr_en=8'hFF and stay exactly PWR_CYC cycles, then go to DRIVE.
REQ-022 DRIVE SHALL put the latched operands on nrn_d for one cycle, then go to SETTLE.
- nrn_d holds that value until the next DRIVE.
REQ-023 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to CAPT.
REQ-024 CAPT SHALL register nrn_q into resp_data, then go to RESP.
REQ-025 RESP SHALL hold resp_valid=1 and stable resp_data/resp_id until resp_valid&&resp_ready, then go to IDLE.
REQ-026 Grant-to-resp_valid latency SHALL be:
- 3+SETTLE_CYC cycles when powered;
- 3+PWR_CYC+SETTLE_CYC cycles when unpowered.
REQ-027 In IDLE with no req_valid, an idle counter SHALL increment.
- at IDLE_OFF it clears nrn_pwr_en to 0.
- any grant or non-IDLE state resets it to 0.
REQ-028 req_valid arriving during a non-IDLE state SHALL wait; it is never dropped or reordered relative to the rr_ptr order.
REQ-029 req_valid deasserted before grant SHALL NOT be granted.
REQ-030 At most one request SHALL be in flight; req_ready is never asserted outside IDLE.
REQ-031 The neuron is combinational: the scheduler SHALL NOT sample nrn_q in any state other than CAPT.

Reset
REQ-032 RSTB low SHALL immediately set all outputs as follows:
- state IDLE;
- req_ready=0, resp_valid=0, resp_data=0, resp_id=0;
- nrn_d=0, nrn_pwr_en=0, busy=0;
- rr_ptr=0, idle counter=0.
REQ-033 Reset mid-operation SHALL discard the in-flight request without producing a response.

Structure
REQ-034 A shared package neuron_pkg SHALL hold:
- the state enum;
- operand width 8 and operand count 8;
- default SETTLE_CYC/PWR_CYC/IDLE_OFF.
REQ-035 The round-robin arbiter SHALL be a sub-module rr_arb(NREQ) with inputs req and ptr and a one-hot grant output.

Verification
REQ-036 Powered: requester 0 sends D0..D7=10,20,30,40,1,2,3,4 -> resp_data=110, resp_id=0, exactly 3+SETTLE_CYC cycles after req_ready.
REQ-037 Operands summing negative via neuron input encoding -> resp_data=0 (ReLU).
REQ-038 All four req_valid held high from reset -> grant order 0,1,2,3,0; each grant follows the prior RESP handshake.
REQ-039 After IDLE_OFF idle cycles nrn_pwr_en=0; the next request shows PWRUP for PWR_CYC cycles with nrn_pwr_en=8'hFF before nrn_d changes.
REQ-040 resp_ready held low for 5 cycles -> resp_valid/resp_data stable; no new req_ready until the handshake completes.
REQ-041 RSTB asserted in SETTLE -> all outputs at reset values the same cycle; no resp_valid after release without a new request.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state encoding, operand geometry and timing defaults for the neuron scheduler
package neuron_pkg;
    typedef enum logic [2:0] {IDLE, PWRUP, DRIVE, SETTLE, CAPT, RESP} state_t;
    localparam int OPW            = 8;
    localparam int OPN            = 8;
    localparam int SETTLE_CYC_DEF = 4;
    localparam int PWR_CYC_DEF    = 2;
    localparam int IDLE_OFF_DEF   = 8;
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/neuron_sched_if.sv
// neuron_sched_if: requester, response and neuron-side signals of the scheduler
interface neuron_sched_if import neuron_pkg::*; #(parameter int NREQ = 4);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*OPN*OPW-1:0] req_data;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [OPW-1:0]          resp_data;
    logic [idw(NREQ)-1:0]    resp_id;
    logic [OPN*OPW-1:0]      nrn_d;
    logic [OPW-1:0]          nrn_q;
    logic [OPN-1:0]          nrn_pwr_en;
    logic                    busy;
    modport master (
        output req_valid, req_data, resp_ready, nrn_q,
        input  req_ready, resp_valid, resp_data, resp_id, nrn_d, nrn_pwr_en, busy
    );
    modport slave (
        input  req_valid, req_data, resp_ready, nrn_q,
        output req_ready, resp_valid, resp_data, resp_id, nrn_d, nrn_pwr_en, busy
    );
endinterface

// File: rtl/rr_arb.sv
// rr_arb: one-hot round-robin grant, lowest index at or after ptr wins
module rr_arb import neuron_pkg::*; #(parameter int NREQ = 4) (
    input  logic [NREQ-1:0]      req,
    input  logic [idw(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]      gnt
);
    localparam int IW = idw(NREQ);
    logic [IW-1:0] idx;
    // scan from the farthest offset down so the closest requester to ptr is the last write
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (req[idx]) gnt = NREQ'(1) << idx;
        end
    end
endmodule

// File: rtl/neuron_sched.sv
// neuron_sched: round-robin scheduler sharing one power-gated combinational neuron
module neuron_sched import neuron_pkg::*; #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int PWR_CYC    = PWR_CYC_DEF,
    parameter int IDLE_OFF   = IDLE_OFF_DEF
) (
    input logic           CK,
    input logic           RSTB,
    neuron_sched_if.slave bus
);
    localparam int IW  = idw(NREQ);
    localparam int DW  = OPN * OPW;
    localparam int CW  = $clog2((SETTLE_CYC > PWR_CYC ? SETTLE_CYC : PWR_CYC) + 1);
    localparam int ICW = $clog2(IDLE_OFF + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [ICW-1:0]  idle_cnt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   g;
    logic [IW-1:0]   lat_id;
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   sel_data;
    logic [DW-1:0]   lat_data;

    rr_arb #(.NREQ(NREQ)) u_arb (.req(bus.req_valid), .ptr(rr_ptr), .gnt(gnt));

    // encode the one-hot grant into the winning requester index
    always_comb begin
        g = '0;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) g = IW'(i);
    end

    assign sel_data      = bus.req_data[int'(g) * DW +: DW];
    // accept is a same-cycle handshake so a requester that drops valid is never granted
    assign bus.req_ready = (RSTB && state == IDLE) ? gnt : '0;
    assign bus.busy      = state != IDLE;

    // scheduler FSM: grant, optional power-up, drive, settle, capture, hold response
    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            state          <= IDLE;
            cnt            <= '0;
            idle_cnt       <= '0;
            rr_ptr         <= '0;
            lat_id         <= '0;
            lat_data       <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_id    <= '0;
            bus.nrn_d      <= '0;
            bus.nrn_pwr_en <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        lat_data <= sel_data;
                        lat_id   <= g;
                        rr_ptr   <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
                        idle_cnt <= '0;
                        cnt      <= '0;
                        if (bus.nrn_pwr_en == '0) begin
                            state          <= PWRUP;
                            bus.nrn_pwr_en <= '1;
                        end else begin
                            state     <= DRIVE;
                            bus.nrn_d <= sel_data;
                        end
                    end else if (idle_cnt != ICW'(IDLE_OFF)) begin
                        idle_cnt <= idle_cnt + 1'b1;
                        if (idle_cnt == ICW'(IDLE_OFF - 1)) bus.nrn_pwr_en <= '0;
                    end
                end
                PWRUP: begin
                    if (cnt == CW'(PWR_CYC - 1)) begin
                        state     <= DRIVE;
                        cnt       <= '0;
                        bus.nrn_d <= lat_data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: state <= SETTLE;
                SETTLE: begin
                    if (cnt == CW'(SETTLE_CYC - 1)) begin
                        state <= CAPT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPT: begin
                    bus.resp_data  <= bus.nrn_q;
                    bus.resp_id    <= lat_id;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_sched.sv
// tb_neuron_sched: directed vector table plus corner-case sequences for neuron_sched
module tb_neuron_sched;
    localparam int S   = 4;
    localparam int P   = 2;
    localparam int OFF = 8;

    typedef struct {
        int          id;
        logic [63:0] d;
        logic [7:0]  q;
    } vec_t;

    logic CK = 1'b0;
    logic RSTB = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t vt[5];

    neuron_sched_if #(.NREQ(4)) bus ();

    neuron_sched #(.NREQ(4), .SETTLE_CYC(S), .PWR_CYC(P), .IDLE_OFF(OFF)) dut (
        .CK(CK), .RSTB(RSTB), .bus(bus)
    );

    always #5 CK = ~CK;

    // combinational neuron: signed operand sum, ReLU, clipped to 8 bits
    function automatic logic [7:0] neuron(input logic [63:0] d);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'($signed(d[k*8 +: 8]));
        return (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
    endfunction

    assign bus.nrn_q = neuron(bus.nrn_d);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_resp_valid"}, bus.resp_valid, 0);
        chk({tag, "_resp_data"}, bus.resp_data, 0);
        chk({tag, "_resp_id"}, bus.resp_id, 0);
        chk({tag, "_nrn_d"}, bus.nrn_d, 0);
        chk({tag, "_pwr_en"}, bus.nrn_pwr_en, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (!bus.resp_valid && n < 40) begin
            @(negedge CK);
            #1;
            n++;
        end
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        @(negedge CK);
        bus.resp_ready = 1'b0;
        #1;
    endtask

    task automatic send(input int id, input logic [63:0] d, input logic [7:0] q);
        int n;
        @(negedge CK);
        bus.req_data[id*64 +: 64] = d;
        bus.req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 40) begin
            @(negedge CK);
            #1;
            n++;
        end
        chk("grant", bus.req_ready, 64'(1) << id);
        @(negedge CK);
        bus.req_valid[id] = 1'b0;
        #1;
        wait_resp(n);
        chk("latency", n, 3 + S);
        chk("resp_data", bus.resp_data, q);
        chk("resp_id", bus.resp_id, id);
        chk("nrn_d_hold", bus.nrn_d, d);
        handshake();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [63:0] d1, d2, dp, dr;
        vt[0] = '{0, {8'd4, 8'd3, 8'd2, 8'd1, 8'd40, 8'd30, 8'd20, 8'd10}, 8'd110};
        vt[1] = '{2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hF6, 8'd5}, 8'd0};
        vt[2] = '{1, {8'd0, 8'd0, 8'd0, 8'd0, 8'hCE, 8'd100, 8'd100, 8'd100}, 8'd250};
        vt[3] = '{3, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd127, 8'd127, 8'h80}, 8'd127};
        vt[4] = '{0, {8{8'hFF}}, 8'd0};
        d1 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd5};
        d2 = {8{8'd1}};
        dp = {8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd25};
        dr = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9};
        bus.req_valid = '1;
        bus.req_data = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge CK);
        #1;
        rst_chk("reset");

        // all requesters valid from reset: strict round robin, one in flight
        @(negedge CK);
        RSTB = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.req_ready == '0 && n < 40) begin
                @(negedge CK);
                #1;
                n++;
            end
            chk("rr_order", bus.req_ready, 64'(1) << (k % 4));
            @(negedge CK);
            if (k == 4) bus.req_valid = '0;
            #1;
            wait_resp(n);
            chk("rr_resp_id", bus.resp_id, k % 4);
            chk("rr_no_ready_in_resp", bus.req_ready, 0);
            handshake();
        end

        for (int i = 0; i < 5; i++) send(vt[i].id, vt[i].d, vt[i].q);

        // back-pressure: response held stable, waiting request not accepted until handshake
        @(negedge CK);
        bus.req_data[64 +: 64] = d1;
        bus.req_valid[1] = 1'b1;
        #1;
        chk("bp_grant1", bus.req_ready, 4'b0010);
        @(negedge CK);
        bus.req_valid[1] = 1'b0;
        bus.req_data[128 +: 64] = d2;
        bus.req_valid[2] = 1'b1;
        #1;
        wait_resp(n);
        chk("bp_latency", n, 3 + S);
        chk("bp_resp_id", bus.resp_id, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge CK);
            #1;
            chk("bp_valid_hold", bus.resp_valid, 1);
            chk("bp_data_hold", bus.resp_data, 12);
            chk("bp_no_ready", bus.req_ready, 0);
        end
        handshake();
        chk("bp_grant2", bus.req_ready, 4'b0100);
        @(negedge CK);
        bus.req_valid[2] = 1'b0;
        #1;
        wait_resp(n);
        chk("bp2_resp_id", bus.resp_id, 2);
        chk("bp2_resp_data", bus.resp_data, 8);
        handshake();

        // supplies stay on through IDLE_OFF-1 idle cycles, drop at IDLE_OFF
        repeat (OFF - 1) @(negedge CK);
        #1;
        chk("pwr_still_on", bus.nrn_pwr_en, 8'hFF);
        @(negedge CK);
        #1;
        chk("pwr_gated", bus.nrn_pwr_en, 0);

        // unpowered request: PWRUP with supplies on before operands change
        @(negedge CK);
        bus.req_data[0 +: 64] = dp;
        bus.req_valid[0] = 1'b1;
        #1;
        chk("pwr_grant", bus.req_ready, 4'b0001);
        n = 0;
        do begin
            @(negedge CK);
            bus.req_valid[0] = 1'b0;
            #1;
            n++;
            if (n <= P) begin
                chk("pwrup_en", bus.nrn_pwr_en, 8'hFF);
                chk("pwrup_d_old", bus.nrn_d, d2);
            end
            if (n == P + 1) chk("drive_d_new", bus.nrn_d, dp);
        end while (!bus.resp_valid && n < 40);
        chk("pwr_latency", n, 3 + P + S);
        chk("pwr_resp_data", bus.resp_data, 75);
        chk("pwr_resp_id", bus.resp_id, 0);
        handshake();

        // reset asserted during SETTLE discards the request
        @(negedge CK);
        bus.req_data[64 +: 64] = dr;
        bus.req_valid[1] = 1'b1;
        #1;
        chk("rst_grant", bus.req_ready, 4'b0010);
        @(negedge CK);
        bus.req_valid[1] = 1'b0;
        repeat (2) @(negedge CK);
        #1;
        chk("settle_busy", bus.busy, 1);
        chk("pre_rst_data", bus.resp_data, 75);
        #1;
        RSTB = 1'b0;
        #1;
        rst_chk("midrst");
        @(negedge CK);
        RSTB = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge CK);
            #1;
            if (bus.resp_valid) n++;
        end
        chk("no_resp_after_rst", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
